// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry for the packet-buffer and key-FIFO
// instances, plus the pointer-width helper.
package fifo_pkg;

  localparam int unsigned FIFO_DEF_DEPTH  = 64;
  localparam int unsigned FIFO_DEF_DATA_W = 8;

  // Pointer width is index width plus one wrap bit, so full and empty differ.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctr.sv
// FIFO pointer register with clear, load and increment, in that priority order.
module fifo_ptr_ctr #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (load_i) begin
      ptr_d = load_val_i;
    end else if (inc_i) begin
      ptr_d = ptr_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/packet_fifo.sv
// Packet-holding FWFT FIFO: written bytes stay pending until committed (readable)
// or discarded (dropped), so a packet with a bad CRC never reaches the reader.
module packet_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DEF_DATA_W,
  parameter int unsigned DEPTH  = FIFO_DEF_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned AF_TH  = DEPTH - 4,
  parameter int unsigned AE_TH  = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              w_enable,
  input  logic [DATA_W-1:0] w_data,
  input  logic              w_commit,
  input  logic              w_discard,
  input  logic              r_enable,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W:0]   free,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  cm_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr_adv;
  logic [PTR_W-1:0]  used;
  logic              wr_accept;
  logic              rd_accept;
  logic              do_discard;
  logic              do_commit;
  logic              overflow_q;
  logic              overflow_d;
  logic              underflow_q;
  logic              underflow_d;
  logic [DATA_W-1:0] mem [DEPTH];

  // Accept decisions use pre-edge flags; clear masks every other request.
  assign wr_accept  = w_enable && !full && !clear;
  assign rd_accept  = r_enable && !empty && !clear;
  assign do_discard = w_discard && !clear;
  assign do_commit  = w_commit && !w_discard && !clear;

  // Commit target includes a write accepted in the same cycle.
  assign wr_ptr_adv = wr_ptr + PTR_W'(wr_accept);

  fifo_ptr_ctr #(.W(PTR_W)) u_wr_ptr (
    .clk        (clk),
    .n_rst      (n_rst),
    .clr_i      (clear),
    .load_i     (do_discard),
    .load_val_i (cm_ptr),
    .inc_i      (wr_accept),
    .ptr_o      (wr_ptr)
  );

  fifo_ptr_ctr #(.W(PTR_W)) u_cm_ptr (
    .clk        (clk),
    .n_rst      (n_rst),
    .clr_i      (clear),
    .load_i     (do_commit),
    .load_val_i (wr_ptr_adv),
    .inc_i      (1'b0),
    .ptr_o      (cm_ptr)
  );

  fifo_ptr_ctr #(.W(PTR_W)) u_rd_ptr (
    .clk        (clk),
    .n_rst      (n_rst),
    .clr_i      (clear),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (rd_accept),
    .ptr_o      (rd_ptr)
  );

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr[ADDR_W-1:0]] <= w_data;
    end
  end

  assign r_data = mem[rd_ptr[ADDR_W-1:0]];

  // Sticky error flags; only clear or reset drops them.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (w_enable && full) begin
        overflow_d = 1'b1;
      end
      if (r_enable && empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign used         = wr_ptr - rd_ptr;
  assign count        = cm_ptr - rd_ptr;
  assign free         = PTR_W'(DEPTH) - used;
  assign empty        = (cm_ptr == rd_ptr);
  assign full         = (used == PTR_W'(DEPTH));
  assign almost_full  = (used >= PTR_W'(AF_TH));
  assign almost_empty = (count <= PTR_W'(AE_TH));
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_packet_fifo.sv
// Bench for packet_fifo (DEPTH=8): directed packet scenarios plus random traffic,
// checked against a queue model of committed and pending bytes.
module tb_packet_fifo;

  localparam int unsigned DW = 8;
  localparam int unsigned DP = 8;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          clear;
  logic          w_enable;
  logic [DW-1:0] w_data;
  logic          w_commit;
  logic          w_discard;
  logic          r_enable;
  logic [DW-1:0] r_data;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic [AW:0]   free;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  int n_checks = 0;
  int n_fail   = 0;

  byte unsigned m_com[$];
  byte unsigned m_pend[$];
  bit           m_ovf;
  bit           m_udf;

  always #5 clk = ~clk;

  packet_fifo #(
    .DATA_W (DW),
    .DEPTH  (DP)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .w_enable     (w_enable),
    .w_data       (w_data),
    .w_commit     (w_commit),
    .w_discard    (w_discard),
    .r_enable     (r_enable),
    .r_data       (r_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .free         (free),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every output against the model's view of the FIFO.
  task automatic check_all(input string where);
    int used_m;
    int cnt_m;
    used_m = m_com.size() + m_pend.size();
    cnt_m  = m_com.size();
    check_eq({where, ":empty"}, 32'(empty), 32'(cnt_m == 0));
    check_eq({where, ":full"},  32'(full),  32'(used_m == DP));
    check_eq({where, ":count"}, 32'(count), 32'(cnt_m));
    check_eq({where, ":free"},  32'(free),  32'(DP - used_m));
    check_eq({where, ":afull"}, 32'(almost_full),  32'(used_m >= DP - 4));
    check_eq({where, ":aempty"}, 32'(almost_empty), 32'(cnt_m <= 4));
    check_eq({where, ":ovf"},   32'(overflow),  32'(m_ovf));
    check_eq({where, ":udf"},   32'(underflow), 32'(m_udf));
    if (cnt_m != 0) begin
      check_eq({where, ":rdata"}, 32'(r_data), 32'(m_com[0]));
    end
  endtask

  // Reference behaviour for one clock edge, from pre-edge model state.
  task automatic model_step(input bit we, input byte unsigned wd, input bit cm,
                            input bit ds, input bit re, input bit cl);
    bit full_pre;
    bit empty_pre;
    if (cl) begin
      m_com.delete();
      m_pend.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      full_pre  = (m_com.size() + m_pend.size()) == DP;
      empty_pre = (m_com.size() == 0);
      if (re) begin
        if (!empty_pre) void'(m_com.pop_front());
        else m_udf = 1'b1;
      end
      if (we) begin
        if (!full_pre) m_pend.push_back(wd);
        else m_ovf = 1'b1;
      end
      if (ds) begin
        m_pend.delete();
      end else if (cm) begin
        foreach (m_pend[i]) m_com.push_back(m_pend[i]);
        m_pend.delete();
      end
    end
  endtask

  task automatic cycle(input bit we, input byte unsigned wd, input bit cm, input bit ds,
                       input bit re, input bit cl, input string where);
    w_enable  = we;
    w_data    = wd;
    w_commit  = cm;
    w_discard = ds;
    r_enable  = re;
    clear     = cl;
    @(posedge clk);
    model_step(we, wd, cm, ds, re, cl);
    #1;
    w_enable  = 1'b0;
    w_commit  = 1'b0;
    w_discard = 1'b0;
    r_enable  = 1'b0;
    clear     = 1'b0;
    check_all(where);
  endtask

  initial begin
    n_rst = 1'b0;
    clear = 1'b0;
    w_enable = 1'b0;
    w_data = '0;
    w_commit = 1'b0;
    w_discard = 1'b0;
    r_enable = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    n_rst = 1'b1;

    // Pending bytes invisible until commit.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h11 + i), 1'b0, 1'b0, 1'b0, 1'b0, "s1_wr");
    check_eq("s1_pend_free", 32'(free), 32'd5);
    check_eq("s1_pend_empty", 32'(empty), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "s1_commit");
    check_eq("s1_count", 32'(count), 32'd3);
    check_eq("s1_rdata", 32'(r_data), 32'h11);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "s1_rd");

    // Discard drops the whole packet, including a same-cycle write.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0, 1'b0, "s2_wr");
    cycle(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, "s2_discard");
    check_eq("s2_free", 32'(free), 32'd8);
    cycle(1'b1, 8'hB0, 1'b1, 1'b0, 1'b0, 1'b0, "s2_wr_commit");
    check_eq("s2_rdata", 32'(r_data), 32'hB0);
    check_eq("s2_count", 32'(count), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "s2_rd");

    // Fill across the pointer wrap, overflow, then drain in order.
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'hC0 + i), i == 7, 1'b0, 1'b0, 1'b0, "s3_fill");
    check_eq("s3_full", 32'(full), 32'd1);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, "s3_ovf");
    check_eq("s3_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "s3_drain");

    // Underflow, then clear drops both sticky flags.
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "s4_udf");
    check_eq("s4_udf", 32'(underflow), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "s4_clear");

    // Full with read and write together: read wins, write rejected.
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'hD0 + i), i == 7, 1'b0, 1'b0, 1'b0, "s5_fill");
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, "s5_rw_full");
    check_eq("s5_free", 32'(free), 32'd1);
    check_eq("s5_rdata", 32'(r_data), 32'hD1);

    // Asynchronous reset with a packet half committed.
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "s6_clear");
    for (int i = 0; i < 2; i++) cycle(1'b1, 8'(8'h60 + i), i == 1, 1'b0, 1'b0, 1'b0, "s6_cm");
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0, 1'b0, "s6_pend");
    #3;
    n_rst = 1'b0;
    #1;
    m_com.delete();
    m_pend.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_all("s6_async_rst");
    check_eq("s6_free", 32'(free), 32'd8);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "s6_stale_commit");
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "s6_stale_rd");

    // Random traffic.
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "rnd_init");
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(99) < 60, 8'($urandom), $urandom_range(99) < 15,
            $urandom_range(99) < 5, $urandom_range(99) < 45, $urandom_range(99) < 1, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
